night_fade_ctrl: RTL and testbench

//  Generates the day/night fade level consumed by the VGA colour-inversion stage.

---
 rtl/night_fade_ctrl_pkg.sv | 19 +
 rtl/night_fade_ctrl_ticker.sv | 26 ++
 rtl/night_fade_ctrl.sv | 130 +++++++++++++
 tb/tb_night_fade_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/night_fade_ctrl_pkg.sv
// Shared types for the day/night fade controller.
// Holds the phase encoding, the fade level width and a phase decode helper.
package night_fade_ctrl_pkg;

  localparam int LEVEL_W = 4;

  typedef enum logic [1:0] {
    DAY   = 2'd0,
    DUSK  = 2'd1,
    NIGHT = 2'd2,
    DAWN  = 2'd3
  } fade_state_t;

  // Night is "on" while the screen is darkening or fully dark.
  function automatic logic is_dark(input fade_state_t s);
    return (s == DUSK) || (s == NIGHT);
  endfunction

endpackage

// File: rtl/night_fade_ctrl_ticker.sv
// Free-running divider that emits a one-cycle step tick every 2**W clocks.
// A synchronous clear restarts the count so a game restart realigns the ramp.
module night_fade_ctrl_ticker #(
  parameter int W = 23
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic step_tick
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign step_tick = &count_reg;

endmodule

// File: rtl/night_fade_ctrl.sv
// Day/night fade level generator driven by game score milestones.
// Ramps fade_level up at dusk and down at dawn, one step per divider tick.
module night_fade_ctrl
  import night_fade_ctrl_pkg::*;
#(
  parameter int SCORE_W    = 14,
  parameter int MILESTONE  = 700,
  parameter int NIGHT_SPAN = 150,
  parameter int STEP_DIV_W = 23,
  parameter int LEVEL_MAX  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SCORE_W-1:0] game_score,
  output logic [LEVEL_W-1:0] fade_level,
  output logic               night,
  output logic               fade_busy,
  output logic               night_start
);

  localparam int TW = SCORE_W + 1;
  localparam logic [TW-1:0]      MS_INIT = TW'(MILESTONE);
  localparam logic [TW-1:0]      TH_SAT  = '1;
  localparam logic [LEVEL_W-1:0] LVL_MAX = LEVEL_W'(LEVEL_MAX);

  if (MILESTONE <= 0) begin : g_bad_milestone
    $error("MILESTONE must be nonzero");
  end
  if (NIGHT_SPAN >= MILESTONE) begin : g_bad_span
    $error("NIGHT_SPAN must be smaller than MILESTONE");
  end
  if (LEVEL_MAX < 1 || LEVEL_MAX > 15) begin : g_bad_level
    $error("LEVEL_MAX must fit in 4 bits");
  end

  fade_state_t        state_reg, state_next;
  logic [LEVEL_W-1:0] level_reg, level_next;
  logic [TW-1:0]      next_ms_reg, next_ms_next;
  logic [TW-1:0]      night_end_reg, night_end_next;
  logic               night_start_reg, night_start_next;

  logic          step_tick;
  logic          restart;
  logic          ms_hit;
  logic          end_hit;
  logic [TW-1:0] score_ext;
  logic [TW:0]   ms_sum;
  logic [TW:0]   end_sum;

  assign restart   = (game_score == '0);
  assign score_ext = {1'b0, game_score};
  assign ms_hit    = (score_ext >= next_ms_reg);
  assign end_hit   = is_dark(state_reg) && !ms_hit && (score_ext >= night_end_reg);

  // One extra bit catches overflow so the thresholds saturate instead of wrapping.
  assign ms_sum  = {1'b0, next_ms_reg} + (TW + 1)'(MILESTONE);
  assign end_sum = {1'b0, score_ext} + (TW + 1)'(NIGHT_SPAN);

  night_fade_ctrl_ticker #(
    .W(STEP_DIV_W)
  ) u_ticker (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (restart),
    .step_tick(step_tick)
  );

  always_comb begin
    state_next       = state_reg;
    level_next       = level_reg;
    next_ms_next     = next_ms_reg;
    night_end_next   = night_end_reg;
    night_start_next = 1'b0;

    if (restart) begin
      state_next     = DAY;
      level_next     = '0;
      next_ms_next   = MS_INIT;
      night_end_next = '0;
    end else begin
      if (ms_hit) begin
        next_ms_next     = ms_sum[TW]  ? TH_SAT : ms_sum[TW-1:0];
        night_end_next   = end_sum[TW] ? TH_SAT : end_sum[TW-1:0];
        night_start_next = 1'b1;
      end

      case (state_reg)
        DAY: begin
          if (ms_hit) state_next = DUSK;
        end
        DUSK: begin
          if (step_tick && level_reg < LVL_MAX) level_next = level_reg + LEVEL_W'(1);
          if (end_hit) state_next = DAWN;
          else if (level_reg == LVL_MAX) state_next = NIGHT;
        end
        NIGHT: begin
          if (end_hit) state_next = DAWN;
        end
        DAWN: begin
          if (step_tick && level_reg != '0) level_next = level_reg - LEVEL_W'(1);
          if (ms_hit) state_next = DUSK;
          else if (level_reg == '0) state_next = DAY;
        end
        default: state_next = DAY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= DAY;
      level_reg       <= '0;
      next_ms_reg     <= MS_INIT;
      night_end_reg   <= '0;
      night_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      level_reg       <= level_next;
      next_ms_reg     <= next_ms_next;
      night_end_reg   <= night_end_next;
      night_start_reg <= night_start_next;
    end
  end

  assign fade_level  = level_reg;
  assign night       = is_dark(state_reg);
  assign fade_busy   = (state_reg == DUSK) || (state_reg == DAWN);
  assign night_start = night_start_reg;

endmodule

// File: tb/tb_night_fade_ctrl.sv
// Self-checking bench for night_fade_ctrl: directed scenarios followed by a
// random score walk, all compared every cycle against a score-rule model.
module tb_night_fade_ctrl;

  localparam int SCORE_W    = 14;
  localparam int MILESTONE  = 700;
  localparam int NIGHT_SPAN = 150;
  localparam int STEP_DIV_W = 2;
  localparam int LEVEL_MAX  = 15;
  localparam int DIV_MOD    = 1 << STEP_DIV_W;
  localparam int TH_SAT     = (1 << (SCORE_W + 1)) - 1;
  localparam int SCORE_MAX  = (1 << SCORE_W) - 1;

  localparam int P_DAY = 0, P_DUSK = 1, P_NIGHT = 2, P_DAWN = 3;

  logic               clk;
  logic               rst_n;
  logic [SCORE_W-1:0] game_score;
  logic [3:0]         fade_level;
  logic               night;
  logic               fade_busy;
  logic               night_start;

  int n_checks = 0;
  int n_errors = 0;

  night_fade_ctrl #(
    .SCORE_W   (SCORE_W),
    .MILESTONE (MILESTONE),
    .NIGHT_SPAN(NIGHT_SPAN),
    .STEP_DIV_W(STEP_DIV_W),
    .LEVEL_MAX (LEVEL_MAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .game_score (game_score),
    .fade_level (fade_level),
    .night      (night),
    .fade_busy  (fade_busy),
    .night_start(night_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase, level, cycles since the last divider restart,
  // and the two score thresholds as plain integers.
  int m_phase, m_level, m_div, m_next_ms, m_night_end;
  int m_start;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0d expected %0d (t=%0t, score=%0d)", tag, got, exp, $time, game_score);
    end
  endtask

  function automatic int sat(input int v);
    return (v > TH_SAT) ? TH_SAT : v;
  endfunction

  task automatic model_reset();
    m_phase = P_DAY; m_level = 0; m_div = 0;
    m_next_ms = MILESTONE; m_night_end = 0; m_start = 0;
  endtask

  task automatic model_edge(input int s);
    bit tick, hit, dark, endh;
    int nph, nl;
    if (s == 0) begin
      model_reset();
      return;
    end
    tick  = (m_div == DIV_MOD - 1);
    m_div = (m_div + 1) % DIV_MOD;
    hit   = (s >= m_next_ms);
    dark  = (m_phase == P_DUSK) || (m_phase == P_NIGHT);
    endh  = dark && !hit && (s >= m_night_end);
    nph = m_phase;
    nl  = m_level;
    case (m_phase)
      P_DAY:   if (hit) nph = P_DUSK;
      P_DUSK: begin
        if (tick) nl = (m_level + 1 > LEVEL_MAX) ? LEVEL_MAX : m_level + 1;
        if (endh) nph = P_DAWN;
        else if (m_level == LEVEL_MAX) nph = P_NIGHT;
      end
      P_NIGHT: if (endh) nph = P_DAWN;
      default: begin
        if (tick) nl = (m_level > 0) ? m_level - 1 : 0;
        if (hit) nph = P_DUSK;
        else if (m_level == 0) nph = P_DAY;
      end
    endcase
    if (hit) begin
      m_next_ms   = sat(m_next_ms + MILESTONE);
      m_night_end = sat(s + NIGHT_SPAN);
    end
    m_start = hit;
    m_phase = nph;
    m_level = nl;
  endtask

  task automatic compare();
    check("fade_level", int'(fade_level), m_level);
    check("night", int'(night), int'(m_phase == P_DUSK || m_phase == P_NIGHT));
    check("fade_busy", int'(fade_busy), int'(m_phase == P_DUSK || m_phase == P_DAWN));
    check("night_start", int'(night_start), m_start);
  endtask

  task automatic step(input int s);
    int sv;
    sv = s;
    game_score = sv[SCORE_W-1:0];
    @(posedge clk);
    model_edge(s);
    #1;
    compare();
  endtask

  task automatic run_until(input string tag, input int s, input int ph, input int lvl, input int budget);
    int n;
    n = 0;
    while (!(m_phase == ph && m_level == lvl) && n < budget) begin
      step(s);
      n++;
    end
    check({tag, "_level"}, int'(fade_level), lvl);
    check({tag, "_night"}, int'(night), int'(ph == P_DUSK || ph == P_NIGHT));
    $display("%s: reached level %0d after %0d cycles", tag, lvl, n);
  endtask

  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_level", int'(fade_level), 0);
    check("async_rst_night", int'(night), 0);
    check("async_rst_busy", int'(fade_busy), 0);
    check("async_rst_start", int'(night_start), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int pulses;
    int s, r, d;
    rst_n = 1'b0;
    game_score = SCORE_W'(1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare();
    rst_n = 1'b1;

    // Milestone at 700 ramps up to full night, 850 ramps back to day.
    repeat (5) step(699);
    check("pre_ms_start", int'(night_start), 0);
    step(700);
    check("ms_pulse", int'(night_start), 1);
    run_until("dusk_full", 700, P_NIGHT, LEVEL_MAX, 200);
    check("night_not_busy", int'(fade_busy), 0);
    run_until("dawn_done", 850, P_DAY, 0, 200);

    // Dawn from a partial dusk at level 5.
    step(0);
    run_until("dusk_part", 700, P_DUSK, 5, 200);
    run_until("dawn_part", 850, P_DAY, 0, 200);

    // Milestone 1400 interrupts dawn at level 9; night ends at 1550.
    step(0);
    run_until("t5_night", 700, P_NIGHT, LEVEL_MAX, 200);
    run_until("t5_dawn9", 850, P_DAWN, 9, 200);
    step(1400);
    check("t5_ms_pulse", int'(night_start), 1);
    run_until("t5_redusk", 1400, P_DUSK, 12, 200);
    repeat (3) step(1549);
    check("t5_still_dark", int'(night), 1);
    run_until("t5_end", 1550, P_DAY, 0, 200);

    // Asynchronous reset in the middle of a dusk ramp.
    step(0);
    run_until("t1_dusk7", 700, P_DUSK, 7, 200);
    async_reset();

    // Multi-milestone jump, then restart rearms the first milestone.
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(2100);
      pulses += int'(night_start);
    end
    check("jump_pulses", pulses, 3);
    check("jump_busy", int'(fade_busy), 1);
    step(0);
    check("restart_level", int'(fade_level), 0);
    check("restart_night", int'(night), 0);
    step(700);
    check("rearm_700", int'(night_start), 1);

    // Random score walk.
    s = 1;
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 99));
      d = int'($urandom_range(1, 40));
      if (r < 1) s = 0;
      else if (r < 3) s = int'($urandom_range(1, SCORE_MAX));
      else if (r < 8) s = (s > d) ? s - d : 1;
      else if (r < 70) s = (s + (d % 13) > SCORE_MAX) ? SCORE_MAX : s + (d % 13);
      step(s);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
